// File: rtl/dmem_axi_master.sv
// -----------------------------------------------------------------------------
// dmem_axi_master
//   AXI4-Lite master for the CPU memory stage. Accepts one load/store request
//   at a time and turns it into a single AXI4-Lite read or write transaction.
//   Stores are lane-replicated with a matching WSTRB; loads have the addressed
//   byte/half extracted from RDATA and sign- or zero-extended.
//
// Build option:
//   DMEM_MASTER_MISALIGN_CHECK_EN  - when defined, misaligned half/word
//       requests issue no AXI traffic and complete with rsp_err in the cycle
//       after acceptance. When undefined, they are force-aligned and issued.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        CPU request handshake (ready only when idle)
//   req_write                  1 = store, 0 = load
//   req_addr, req_wdata        byte address, right-aligned store data
//   req_size                   00 byte, 01 half, 10/11 word
//   req_unsigned               load zero-extends when 1
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_err         extended load data / error flag
//   busy                       a transaction is in progress
//   M_AXI_*                    AXI4-Lite master, 32-bit address and data
// -----------------------------------------------------------------------------
module dmem_axi_master #(
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] M_AXI_AWADDR,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_req_ready;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_arvalid;
    logic [31:0] r_awaddr;
    logic [31:0] r_araddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_accept;
    logic        w_bad;
    logic        w_accept_ok;
    logic        w_accept_bad;
    logic [31:0] w_aligned_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_aw_done;
    logic        w_w_done;

    // Pick the addressed lane out of RDATA and extend it to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] rdata,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = rdata[{lane, 3'b000} +: 8];
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   load_extract = {{24{~uns & byte_v[7]}}, byte_v};
            2'b01:   load_extract = {{16{~uns & half_v[15]}}, half_v};
            default: load_extract = rdata;
        endcase
    endfunction

    // A request is only taken while idle; r_req_ready is 0 in the cycle after
    // reset release so that every output reads 0 during reset.
    assign w_accept = req_valid & r_req_ready;

`ifdef DMEM_MASTER_MISALIGN_CHECK_EN
    logic w_misalign;
    assign w_misalign = ((req_size == 2'b01) & req_addr[0]) |
                        (req_size[1] & (req_addr[1:0] != 2'b00));
    assign w_bad      = w_misalign;
`else
    assign w_bad      = 1'b0;
`endif

    assign w_accept_ok  = w_accept & ~w_bad;
    assign w_accept_bad = w_accept & w_bad;

    // Request decode: size-aligned address, replicated store data and strobes.
    // Replicating the data places the byte/half in every lane, which is the
    // same as shifting it up by 8*addr[1:0] for the lanes WSTRB enables.
    always_comb begin
        w_aligned_addr = req_addr;
        w_wdata        = req_wdata;
        w_wstrb        = 4'b1111;
        case (req_size)
            2'b00: begin
                w_aligned_addr = req_addr;
                w_wdata        = {4{req_wdata[7:0]}};
                w_wstrb        = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                w_aligned_addr = {req_addr[31:1], 1'b0};
                w_wdata        = {2{req_wdata[15:0]}};
                w_wstrb        = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                w_aligned_addr = {req_addr[31:2], 2'b00};
                w_wdata        = req_wdata;
                w_wstrb        = 4'b1111;
            end
        endcase
    end

    assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs    = r_wvalid & M_AXI_WREADY;
    assign w_b_hs    = (r_state == ST_WR_RESP) & M_AXI_BVALID;
    assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs    = (r_state == ST_RD_DATA) & M_AXI_RVALID;
    // A channel is finished once its VALID has dropped or is handshaking now.
    assign w_aw_done = ~r_awvalid | M_AXI_AWREADY;
    assign w_w_done  = ~r_wvalid | M_AXI_WREADY;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_ok) begin
                    if (req_write) begin
                        w_state_nxt = ST_WR_REQ;
                    end else begin
                        w_state_nxt = ST_RD_REQ;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (w_aw_done && w_w_done) begin
                    w_state_nxt = ST_WR_RESP;
                end else begin
                    w_state_nxt = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                if (w_ar_hs) begin
                    w_state_nxt = ST_RD_DATA;
                end else begin
                    w_state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_DATA: begin
                if (w_r_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RD_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // req_ready follows the next state so it is already high in the
    // rsp_valid cycle, allowing back-to-back requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Write address/data channels: load on store accept, drop each VALID on
    // its own handshake while keeping the payload stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awaddr  <= 32'h0000_0000;
            r_wdata   <= 32'h0000_0000;
            r_wstrb   <= 4'b0000;
        end else if (w_accept_ok && req_write) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= w_aligned_addr;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
        end else begin
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
            end
            if (w_w_hs) begin
                r_wvalid <= 1'b0;
            end
        end
    end

    // Read address channel plus the lane/size/sign context for the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arvalid  <= 1'b0;
            r_araddr   <= 32'h0000_0000;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
        end else if (w_accept_ok && !req_write) begin
            r_arvalid  <= 1'b1;
            r_araddr   <= w_aligned_addr;
            r_lane     <= req_addr[1:0];
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
        end else if (w_ar_hs) begin
            r_arvalid  <= 1'b0;
        end
    end

    // Completion pulse; data is zero for stores, errors and non-response cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_rsp_valid <= w_b_hs | w_r_hs | w_accept_bad;
            r_rsp_err   <= (w_b_hs & (M_AXI_BRESP != 2'b00)) |
                           (w_r_hs & (M_AXI_RRESP != 2'b00)) |
                           w_accept_bad;
            if (w_r_hs && (M_AXI_RRESP == 2'b00)) begin
                r_rsp_rdata <= load_extract(M_AXI_RDATA, r_lane, r_size, r_unsigned);
            end else begin
                r_rsp_rdata <= 32'h0000_0000;
            end
        end
    end

    assign req_ready     = r_req_ready;
    assign busy          = (r_state != ST_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_err       = r_rsp_err;
    assign rsp_rdata     = r_rsp_rdata;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = AXI_PROT;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = (r_state == ST_WR_RESP);
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = AXI_PROT;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = (r_state == ST_RD_DATA);

endmodule

// File: tb/tb_dmem_axi_master.sv
// -----------------------------------------------------------------------------
// tb_dmem_axi_master
//   Table-driven bench for dmem_axi_master. Each record holds a request, the
//   slave behaviour (ready delays, response code, read data) and hand-computed
//   expectations. A bench-side AXI4-Lite slave answers each transaction and
//   watches VALID hold/drop behaviour. Hand-written sequences cover reset
//   state, a back-to-back request in the rsp_valid cycle and reset in RD_DATA.
// -----------------------------------------------------------------------------
module tb_dmem_axi_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    dmem_axi_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] s_rdata;   // slave read data
        logic [1:0]  s_resp;    // slave BRESP/RRESP
        int          aw_dly;    // cycles before AWREADY
        int          w_dly;     // cycles before WREADY
        int          ar_dly;    // cycles before ARREADY
        logic        chain;     // present the next record in the rsp_valid cycle
        logic        txn;       // an AXI transaction is expected
        logic        chk_addr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;     // cycles from the first post-accept cycle to rsp_valid
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    // Captured per-transaction results.
    int          n_aw, n_w, n_b, n_ar, n_r, n_rsp, rsp_cyc, viol;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr, cap_rdata;
    logic [3:0]  cap_wstrb;
    logic        cap_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic slave_idle();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_BRESP = 2'b00; M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        M_AXI_RDATA = 32'h0; M_AXI_RRESP = 2'b00;
    endtask

    task automatic set_req(input vec_t v);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
        req_wdata = v.wdata; req_size = v.size; req_unsigned = v.uns;
    endtask

    // Apply one record. pre=1 means the request was already driven by the
    // previous call in its rsp_valid cycle.
    task automatic run_vec(input vec_t v, input vec_t nxt, input bit pre);
        logic        pend_aw, pend_w, pend_ar;
        logic [31:0] hold_aw, hold_wd, hold_ar;
        logic [3:0]  hold_ws;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_rsp = 0;
        rsp_cyc = -1; viol = 0; cap_rdata = 32'h0; cap_err = 1'b0;
        cap_awaddr = 32'h0; cap_wdata = 32'h0; cap_wstrb = 4'h0; cap_araddr = 32'h0;
        pend_aw = 1'b0; pend_w = 1'b0; pend_ar = 1'b0;
        hold_aw = 32'h0; hold_wd = 32'h0; hold_ar = 32'h0; hold_ws = 4'h0;
        if (!pre) begin
            @(negedge clk);
            set_req(v);
        end
        @(negedge clk);
        // Request fields need not be held after acceptance.
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_size = 2'b11;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (rsp_valid) begin
                n_rsp++; cap_rdata = rsp_rdata; cap_err = rsp_err;
                if (rsp_cyc < 0) rsp_cyc = cyc;
            end
            // VALID hold / drop rules and READY confinement.
            if (M_AXI_AWVALID && n_aw > 0) viol++;
            if (M_AXI_WVALID && n_w > 0) viol++;
            if (M_AXI_ARVALID && n_ar > 0) viol++;
            if (pend_aw && !(M_AXI_AWVALID && M_AXI_AWADDR == hold_aw)) viol++;
            if (pend_w && !(M_AXI_WVALID && M_AXI_WDATA == hold_wd && M_AXI_WSTRB == hold_ws)) viol++;
            if (pend_ar && !(M_AXI_ARVALID && M_AXI_ARADDR == hold_ar)) viol++;
            if (v.wr && M_AXI_RREADY) viol++;
            if (!v.wr && M_AXI_BREADY) viol++;
            // Responses only after the request handshakes seen in earlier cycles.
            M_AXI_BVALID = (n_aw > 0 && n_w > 0 && n_b == 0);
            M_AXI_BRESP  = v.s_resp;
            if (M_AXI_BVALID && M_AXI_BREADY) n_b++;
            M_AXI_RVALID = (n_ar > 0 && n_r == 0);
            M_AXI_RDATA  = v.s_rdata;
            M_AXI_RRESP  = v.s_resp;
            if (M_AXI_RVALID && M_AXI_RREADY) n_r++;
            M_AXI_AWREADY = M_AXI_AWVALID && (cyc >= v.aw_dly);
            M_AXI_WREADY  = M_AXI_WVALID && (cyc >= v.w_dly);
            M_AXI_ARREADY = M_AXI_ARVALID && (cyc >= v.ar_dly);
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin n_aw++; cap_awaddr = M_AXI_AWADDR; end
            if (M_AXI_WVALID && M_AXI_WREADY) begin n_w++; cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB; end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin n_ar++; cap_araddr = M_AXI_ARADDR; end
            pend_aw = M_AXI_AWVALID && !M_AXI_AWREADY; hold_aw = M_AXI_AWADDR;
            pend_w  = M_AXI_WVALID && !M_AXI_WREADY;   hold_wd = M_AXI_WDATA; hold_ws = M_AXI_WSTRB;
            pend_ar = M_AXI_ARVALID && !M_AXI_ARREADY; hold_ar = M_AXI_ARADDR;
            if (rsp_cyc >= 0 && v.chain) begin
                chk({v.name, " b2b req_ready"}, 32'(req_ready), 32'h1);
                set_req(nxt);
                break;
            end
            if (rsp_cyc >= 0 && cyc >= rsp_cyc + 2) break;
            @(negedge clk);
        end
        slave_idle();
        chk({v.name, " rsp_cnt"}, 32'(n_rsp), 32'h1);
        chk({v.name, " rdata"}, cap_rdata, v.e_rdata);
        chk({v.name, " err"}, 32'(cap_err), 32'(v.e_err));
        chk({v.name, " latency"}, 32'(rsp_cyc), 32'(v.e_lat));
        chk({v.name, " protocol"}, 32'(viol), 32'h0);
        if (v.txn && v.wr) begin
            chk({v.name, " aw/w/b count"}, {8'(n_aw), 8'(n_w), 8'(n_b), 8'(n_ar)}, 32'h0101_0100);
            chk({v.name, " wdata"}, cap_wdata, v.e_wdata);
            chk({v.name, " wstrb"}, 32'(cap_wstrb), 32'(v.e_wstrb));
            if (v.chk_addr) chk({v.name, " awaddr"}, cap_awaddr, v.e_addr);
        end else if (v.txn) begin
            chk({v.name, " ar/r count"}, {8'(n_aw), 8'(n_w), 8'(n_ar), 8'(n_r)}, 32'h0000_0101);
            if (v.chk_addr) chk({v.name, " araddr"}, cap_araddr, v.e_addr);
        end else begin
            chk({v.name, " no axi"}, {8'(n_aw), 8'(n_w), 8'(n_ar), 8'(n_b)}, 32'h0);
        end
    endtask

    initial begin
        bit prev_chain;
        //            name          wr    addr          wdata         sz     u     s_rdata       rsp    aw w ar ch    txn  chka  e_addr        e_wdata       wstrb    e_rdata       err   lat
        vecs[0]  = '{"st_w_late",   1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,        2'b00, 1, 1, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0,        1'b0, 3};
        vecs[1]  = '{"st_b_103",    1'b1, 32'h0000_0103, 32'h1234_56A5, 2'b00, 1'b0, 32'h0,        2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0,         32'hA5A5_A5A5, 4'b1000, 32'h0,        1'b0, 2};
        vecs[2]  = '{"ld_w_100",    1'b0, 32'h0000_0100, 32'h0,         2'b10, 1'b0, 32'hA5AD_BEEF, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0,         4'b0000, 32'hA5AD_BEEF, 1'b0, 2};
        vecs[3]  = '{"ld_b_s103",   1'b0, 32'h0000_0103, 32'h0,         2'b00, 1'b0, 32'h8000_0000, 2'b00, 0, 0, 2, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 32'hFFFF_FF80, 1'b0, 4};
        vecs[4]  = '{"ld_b_u103",   1'b0, 32'h0000_0103, 32'h0,         2'b00, 1'b1, 32'h8000_0000, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0000_0080, 1'b0, 2};
        vecs[5]  = '{"st_w_early",  1'b1, 32'h0000_010C, 32'h0BAD_F00D, 2'b10, 1'b0, 32'h0,        2'b00, 3, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_010C, 32'h0BAD_F00D, 4'b1111, 32'h0,        1'b0, 5};
        vecs[6]  = '{"ld_slverr",   1'b0, 32'h0000_0200, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h0,         4'b0000, 32'h0,        1'b1, 2};
`ifdef DMEM_MASTER_MISALIGN_CHECK_EN
        vecs[7]  = '{"ld_h_101",    1'b0, 32'h0000_0101, 32'h0,         2'b01, 1'b0, 32'h1234_8765, 2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0,        1'b1, 0};
        vecs[13] = '{"st_w_206",    1'b1, 32'h0000_0206, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0,        2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0,        1'b1, 0};
`else
        vecs[7]  = '{"ld_h_101",    1'b0, 32'h0000_0101, 32'h0,         2'b01, 1'b0, 32'h1234_8765, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0,         4'b0000, 32'hFFFF_8765, 1'b0, 2};
        vecs[13] = '{"st_w_206",    1'b1, 32'h0000_0206, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0,        2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'h0,        1'b0, 2};
`endif
        vecs[8]  = '{"st_h_102",    1'b1, 32'h0000_0102, 32'hFFFF_BEEF, 2'b01, 1'b0, 32'h0,        2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'hBEEF_BEEF, 4'b1100, 32'h0,        1'b0, 2};
        vecs[9]  = '{"st_decerr",   1'b1, 32'h0000_0040, 32'h1111_2222, 2'b10, 1'b0, 32'h0,        2'b11, 0, 2, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222, 4'b1111, 32'h0,        1'b1, 4};
        vecs[10] = '{"ld_h_u102",   1'b0, 32'h0000_0102, 32'h0,         2'b01, 1'b1, 32'hFEDC_1234, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0,         4'b0000, 32'h0000_FEDC, 1'b0, 2};
        vecs[11] = '{"ld_b_s101",   1'b0, 32'h0000_0101, 32'h0,         2'b00, 1'b0, 32'h0000_7F00, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0000_007F, 1'b0, 2};
        vecs[12] = '{"st_sz11",     1'b1, 32'h0000_0010, 32'h1234_5678, 2'b11, 1'b0, 32'h0,        2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h0,        1'b0, 2};
        vecs[14] = '{"ld_b_s102",   1'b0, 32'h0000_0102, 32'h0,         2'b00, 1'b0, 32'h00FF_0000, 2'b00, 0, 0, 1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 32'hFFFF_FFFF, 1'b0, 3};
        vecs[15] = '{"st_h_100",    1'b1, 32'h0000_0100, 32'h5A5A_1234, 2'b01, 1'b0, 32'h0,        2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h1234_1234, 4'b0011, 32'h0,        1'b0, 2};

        // Reset state.
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_size = 2'b00; req_unsigned = 1'b0;
        slave_idle();
        @(negedge clk); @(negedge clk);
        chk("reset ctrl", {23'h0, req_ready, busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                           M_AXI_BREADY, M_AXI_RREADY, rsp_valid, rsp_err}, 32'h0);
        chk("reset awaddr", M_AXI_AWADDR, 32'h0);
        chk("reset araddr", M_AXI_ARADDR, 32'h0);
        chk("reset wdata", M_AXI_WDATA, 32'h0);
        chk("reset wstrb", 32'(M_AXI_WSTRB), 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready", 32'(req_ready), 32'h1);

        // Table of transactions; a chained record hands its successor over
        // in the rsp_valid cycle.
        prev_chain = 1'b0;
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], vecs[(i + 1) % NV], prev_chain);
            prev_chain = vecs[i].chain;
        end

        // Reset while waiting in RD_DATA.
        @(negedge clk);
        set_req(vecs[2]);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid arvalid", 32'(M_AXI_ARVALID), 32'h1);
        M_AXI_ARREADY = 1'b1;
        @(negedge clk);
        M_AXI_ARREADY = 1'b0;
        chk("mid rready", 32'(M_AXI_RREADY), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid reset ctrl", {23'h0, req_ready, busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                               M_AXI_BREADY, M_AXI_RREADY, rsp_valid, rsp_err}, 32'h0);
        chk("mid reset araddr", M_AXI_ARADDR, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid release req_ready", {31'h0, req_ready}, 32'h1);
        run_vec(vecs[3], vecs[3], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
